// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cache_pkg
//  Description : Shared types and default widths for the 2-way set-associative
//                write-back cache controller.
//                - cache_state_t : controller FSM states
//                - data_sel_t    : data-array write source select
//                - default offset/index/tag widths for a 32-bit address
//  Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

    localparam int ADDR_W       = 32;
    localparam int S_OFFSET_DEF = 5;
    localparam int S_INDEX_DEF  = 3;
    localparam int S_TAG_DEF    = ADDR_W - S_OFFSET_DEF - S_INDEX_DEF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WB    = 2'd1,
        S_ALLOC = 2'd2
    } cache_state_t;

    typedef enum logic [0:0] {
        DSEL_CPU = 1'b0,
        DSEL_MEM = 1'b1
    } data_sel_t;

    // A way must be written back before reuse only if it holds modified data.
    function automatic logic needs_writeback(input logic valid, input logic dirty);
        return valid & dirty;
    endfunction

endpackage : cache_pkg
`default_nettype wire

// File: rtl/cache_control_hit_compare.sv
`default_nettype none
// ============================================================================
//  Module      : hit_compare
//  Description : Combinational tag/valid compare for both ways of a set.
//  Ports       : tag0_i/tag1_i     way tag read-outs
//                valid0_i/valid1_i way valid read-outs
//                addr_tag_i        tag field of the CPU address
//                hit0_o/hit1_o     per-way hit
//                hit_o             any way hit
//                hit_way_o         hitting way (way 0 wins if both hit)
//  Revision    : 1.0 - initial release
// ============================================================================
module hit_compare #(
    parameter int s_tag = 24
) (
    input  logic [s_tag-1:0] tag0_i,
    input  logic [s_tag-1:0] tag1_i,
    input  logic             valid0_i,
    input  logic             valid1_i,
    input  logic [s_tag-1:0] addr_tag_i,
    output logic             hit0_o,
    output logic             hit1_o,
    output logic             hit_o,
    output logic             hit_way_o
);

    assign hit0_o    = valid0_i & (tag0_i == addr_tag_i);
    assign hit1_o    = valid1_i & (tag1_i == addr_tag_i);
    assign hit_o     = hit0_o | hit1_o;
    // Way 0 takes priority; way 1 is reported only when way 0 misses.
    assign hit_way_o = ~hit0_o & hit1_o;

endmodule : hit_compare
`default_nettype wire

// File: rtl/cache_control.sv
`default_nettype none
// ============================================================================
//  Module      : cache_control
//  Description : Control FSM for a 2-way set-associative, write-back cache.
//                Decides hit/miss from the tag/valid/dirty/LRU read-outs,
//                drives all array load enables and indices, and sequences
//                victim writeback and line refill towards physical memory.
//  Ports       : clk, rst (async, active-low)
//                mem_read/mem_write/mem_address/mem_resp  CPU side
//                tag_out*/valid_out*/dirty_out*/lru_out   array read-outs
//                arr_rindex/arr_windex, *_load, *_in      array controls
//                data_in_sel, hit_way                     datapath muxes
//                pmem_read/pmem_write/pmem_address/pmem_resp  memory side
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_control
    import cache_pkg::*;
#(
    parameter int s_offset = S_OFFSET_DEF,
    parameter int s_index  = S_INDEX_DEF,
    parameter int s_tag    = 32 - s_offset - s_index
) (
    input  logic               clk,
    input  logic               rst,
    // CPU side
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [31:0]        mem_address,
    output logic               mem_resp,
    // Array read-outs
    input  logic [s_tag-1:0]   tag_out0,
    input  logic [s_tag-1:0]   tag_out1,
    input  logic               valid_out0,
    input  logic               valid_out1,
    input  logic               dirty_out0,
    input  logic               dirty_out1,
    input  logic               lru_out,
    // Array controls
    output logic [s_index-1:0] arr_rindex,
    output logic [s_index-1:0] arr_windex,
    output logic [1:0]         tag_load,
    output logic [1:0]         valid_load,
    output logic [1:0]         dirty_load,
    output logic [1:0]         data_load,
    output logic               valid_in,
    output logic               dirty_in,
    output logic               lru_load,
    output logic               lru_in,
    output logic               data_in_sel,
    output logic               hit_way,
    // Memory side
    output logic               pmem_read,
    output logic               pmem_write,
    output logic [31:0]        pmem_address,
    input  logic               pmem_resp
);

    cache_state_t state_q, state_d;

    logic [s_index-1:0] w_index;
    logic [s_tag-1:0]   w_addr_tag;
    logic [s_tag-1:0]   w_victim_tag;
    logic               w_victim;
    logic               w_victim_wb;
    logic               w_req;
    logic               w_hit0, w_hit1, w_hit, w_hit_way;
    logic               w_unused;

    assign w_index    = mem_address[s_offset +: s_index];
    assign w_addr_tag = mem_address[31 -: s_tag];
    assign w_req      = mem_read | mem_write;

    // The LRU bit names the way to evict.
    assign w_victim     = lru_out;
    assign w_victim_tag = w_victim ? tag_out1 : tag_out0;
    assign w_victim_wb  = w_victim ? needs_writeback(valid_out1, dirty_out1)
                                   : needs_writeback(valid_out0, dirty_out0);

    // Byte offset only matters to the data path; per-way hits fold into hit/hit_way.
    assign w_unused = ^{mem_address[s_offset-1:0], w_hit0, w_hit1};

    hit_compare #(
        .s_tag      (s_tag)
    ) u_hit_compare (
        .tag0_i     (tag_out0),
        .tag1_i     (tag_out1),
        .valid0_i   (valid_out0),
        .valid1_i   (valid_out1),
        .addr_tag_i (w_addr_tag),
        .hit0_o     (w_hit0),
        .hit1_o     (w_hit1),
        .hit_o      (w_hit),
        .hit_way_o  (w_hit_way)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        mem_resp     = 1'b0;
        arr_rindex   = '0;
        arr_windex   = '0;
        tag_load     = 2'b00;
        valid_load   = 2'b00;
        dirty_load   = 2'b00;
        data_load    = 2'b00;
        valid_in     = 1'b0;
        dirty_in     = 1'b0;
        lru_load     = 1'b0;
        lru_in       = 1'b0;
        data_in_sel  = DSEL_CPU;
        hit_way      = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;

        // While reset is low every output is forced to zero combinationally,
        // so a transfer in flight is dropped without waiting for a clock edge.
        if (rst) begin
            arr_rindex = w_index;
            arr_windex = w_index;

            unique case (state_q)
                S_IDLE: begin
                    if (w_req) begin
                        if (w_hit) begin
                            mem_resp = 1'b1;
                            hit_way  = w_hit_way;
                            lru_load = 1'b1;
                            lru_in   = ~w_hit_way;
                            // Read+write together is handled as a write.
                            if (mem_write) begin
                                data_load[w_hit_way]  = 1'b1;
                                data_in_sel           = DSEL_CPU;
                                dirty_load[w_hit_way] = 1'b1;
                                dirty_in              = 1'b1;
                            end
                        end else begin
                            state_d = w_victim_wb ? S_WB : S_ALLOC;
                        end
                    end
                end

                S_WB: begin
                    pmem_write   = 1'b1;
                    pmem_address = {w_victim_tag, w_index, {s_offset{1'b0}}};
                    if (pmem_resp) begin
                        dirty_load[w_victim] = 1'b1;
                        dirty_in             = 1'b0;
                        state_d              = S_ALLOC;
                    end
                end

                S_ALLOC: begin
                    pmem_read    = 1'b1;
                    pmem_address = {mem_address[31:s_offset], {s_offset{1'b0}}};
                    if (pmem_resp) begin
                        data_load[w_victim]  = 1'b1;
                        tag_load[w_victim]   = 1'b1;
                        valid_load[w_victim] = 1'b1;
                        valid_in             = 1'b1;
                        dirty_load[w_victim] = 1'b1;
                        dirty_in             = 1'b0;
                        data_in_sel          = DSEL_MEM;
                        // Back in idle the refreshed line re-compares and hits.
                        state_d              = S_IDLE;
                    end
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

endmodule : cache_control
`default_nettype wire

// File: tb/tb_cache_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cache_control
//  Description : Directed self-checking bench for cache_control. A small
//                behavioural model of the tag/valid/dirty/LRU arrays sits
//                behind the controller so refills and hits close the loop.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_control;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_read = 1'b0, mem_write = 1'b0;
    logic [31:0] mem_address = '0;
    logic        mem_resp;
    logic [23:0] tag_out0, tag_out1;
    logic        valid_out0, valid_out1, dirty_out0, dirty_out1, lru_out;
    logic [2:0]  arr_rindex, arr_windex;
    logic [1:0]  tag_load, valid_load, dirty_load, data_load;
    logic        valid_in, dirty_in, lru_load, lru_in, data_in_sel, hit_way;
    logic        pmem_read, pmem_write;
    logic [31:0] pmem_address;
    logic        pmem_resp = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cache_control dut (
        .clk          (clk),
        .rst          (rst),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_address  (mem_address),
        .mem_resp     (mem_resp),
        .tag_out0     (tag_out0),
        .tag_out1     (tag_out1),
        .valid_out0   (valid_out0),
        .valid_out1   (valid_out1),
        .dirty_out0   (dirty_out0),
        .dirty_out1   (dirty_out1),
        .lru_out      (lru_out),
        .arr_rindex   (arr_rindex),
        .arr_windex   (arr_windex),
        .tag_load     (tag_load),
        .valid_load   (valid_load),
        .dirty_load   (dirty_load),
        .data_load    (data_load),
        .valid_in     (valid_in),
        .dirty_in     (dirty_in),
        .lru_load     (lru_load),
        .lru_in       (lru_in),
        .data_in_sel  (data_in_sel),
        .hit_way      (hit_way),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_resp    (pmem_resp)
    );

    // ------------------------------------------------------------------
    // Behavioural array model (single writer process, preload via pl_*)
    // ------------------------------------------------------------------
    logic [23:0] m_tag0 [8];
    logic [23:0] m_tag1 [8];
    logic [7:0]  m_valid0 = '0, m_valid1 = '0, m_dirty0 = '0, m_dirty1 = '0, m_lru = '0;

    logic        pl_en = 1'b0, pl_way = 1'b0, pl_v = 1'b0, pl_d = 1'b0, pl_lru = 1'b0;
    logic [2:0]  pl_idx = '0;
    logic [23:0] pl_tag = '0;

    assign tag_out0   = m_tag0[arr_rindex];
    assign tag_out1   = m_tag1[arr_rindex];
    assign valid_out0 = m_valid0[arr_rindex];
    assign valid_out1 = m_valid1[arr_rindex];
    assign dirty_out0 = m_dirty0[arr_rindex];
    assign dirty_out1 = m_dirty1[arr_rindex];
    assign lru_out    = m_lru[arr_rindex];

    always @(posedge clk) begin
        if (pl_en) begin
            if (pl_way) begin
                m_tag1[pl_idx]   <= pl_tag;
                m_valid1[pl_idx] <= pl_v;
                m_dirty1[pl_idx] <= pl_d;
            end else begin
                m_tag0[pl_idx]   <= pl_tag;
                m_valid0[pl_idx] <= pl_v;
                m_dirty0[pl_idx] <= pl_d;
            end
            m_lru[pl_idx] <= pl_lru;
        end else begin
            if (tag_load[0])   m_tag0[arr_windex]   <= mem_address[31:8];
            if (tag_load[1])   m_tag1[arr_windex]   <= mem_address[31:8];
            if (valid_load[0]) m_valid0[arr_windex] <= valid_in;
            if (valid_load[1]) m_valid1[arr_windex] <= valid_in;
            if (dirty_load[0]) m_dirty0[arr_windex] <= dirty_in;
            if (dirty_load[1]) m_dirty1[arr_windex] <= dirty_in;
            if (lru_load)      m_lru[arr_windex]    <= lru_in;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic way, input logic [2:0] idx, input logic [23:0] tag,
                           input logic v, input logic d, input logic lru);
        pl_en = 1'b1; pl_way = way; pl_idx = idx; pl_tag = tag; pl_v = v; pl_d = d; pl_lru = lru;
        tick();
        pl_en = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b0; mem_read = 1'b1; mem_address = 32'h0000_0040;
        #3;
        n_cmp++; if (mem_resp !== 1'b0) begin n_err++; $display("FAIL reset_mem_resp: got %b want 0", mem_resp); end
        n_cmp++; if ({pmem_read, pmem_write} !== 2'b00) begin n_err++; $display("FAIL reset_pmem: got %b want 00", {pmem_read, pmem_write}); end
        n_cmp++; if (arr_rindex !== 3'd0) begin n_err++; $display("FAIL reset_rindex: got %0d want 0", arr_rindex); end
        mem_read = 1'b0;
        tick(); tick();
        rst = 1'b1;
        #1;
    endtask

    task automatic test_cold_read_miss();
        mem_address = 32'h0000_0040; mem_read = 1'b1;
        #1;
        n_cmp++; if (mem_resp !== 1'b0) begin n_err++; $display("FAIL cold_miss_resp: got %b want 0", mem_resp); end
        n_cmp++; if (arr_rindex !== 3'd2) begin n_err++; $display("FAIL cold_rindex: got %0d want 2", arr_rindex); end
        tick();
        n_cmp++; if (pmem_read !== 1'b1) begin n_err++; $display("FAIL cold_pmem_read: got %b want 1", pmem_read); end
        n_cmp++; if (pmem_address !== 32'h0000_0040) begin n_err++; $display("FAIL cold_pmem_addr: got %h want 00000040", pmem_address); end
        n_cmp++; if (pmem_write !== 1'b0) begin n_err++; $display("FAIL cold_pmem_write: got %b want 0", pmem_write); end
        tick();
        n_cmp++; if ({pmem_read, pmem_address} !== {1'b1, 32'h0000_0040}) begin n_err++; $display("FAIL cold_hold: got %b/%h want 1/00000040", pmem_read, pmem_address); end
        tick();
        pmem_resp = 1'b1;
        #1;
        n_cmp++; if ({tag_load, valid_load, data_load, dirty_load} !== 8'b01010101) begin n_err++; $display("FAIL cold_loads: got %b want 01010101", {tag_load, valid_load, data_load, dirty_load}); end
        n_cmp++; if ({valid_in, dirty_in, data_in_sel} !== 3'b101) begin n_err++; $display("FAIL cold_in: got %b want 101", {valid_in, dirty_in, data_in_sel}); end
        n_cmp++; if (mem_resp !== 1'b0) begin n_err++; $display("FAIL cold_early_resp: got %b want 0", mem_resp); end
        tick();
        pmem_resp = 1'b0;
        #1;
        n_cmp++; if (mem_resp !== 1'b1) begin n_err++; $display("FAIL cold_hit_resp: got %b want 1", mem_resp); end
        n_cmp++; if ({hit_way, lru_load, lru_in} !== 3'b011) begin n_err++; $display("FAIL cold_hit_lru: got %b want 011", {hit_way, lru_load, lru_in}); end
        n_cmp++; if (pmem_read !== 1'b0) begin n_err++; $display("FAIL cold_hit_pmem: got %b want 0", pmem_read); end
        tick();
        mem_read = 1'b0;
        #1;
    endtask

    task automatic test_read_hit_way1();
        preload(1'b1, 3'd2, 24'h000123, 1'b1, 1'b0, 1'b1);
        mem_address = 32'h0001_2340; mem_read = 1'b1;
        #1;
        n_cmp++; if (mem_resp !== 1'b1) begin n_err++; $display("FAIL hit1_resp: got %b want 1", mem_resp); end
        n_cmp++; if ({hit_way, lru_load, lru_in} !== 3'b110) begin n_err++; $display("FAIL hit1_lru: got %b want 110", {hit_way, lru_load, lru_in}); end
        n_cmp++; if ({pmem_read, pmem_write, data_load, dirty_load} !== 6'b0) begin n_err++; $display("FAIL hit1_quiet: got %b want 000000", {pmem_read, pmem_write, data_load, dirty_load}); end
        tick();
        mem_read = 1'b0;
        #1;
    endtask

    task automatic test_write_hit();
        mem_address = 32'h0000_0040; mem_write = 1'b1;
        #1;
        n_cmp++; if (mem_resp !== 1'b1) begin n_err++; $display("FAIL wr_resp: got %b want 1", mem_resp); end
        n_cmp++; if ({data_load, dirty_load} !== 4'b0101) begin n_err++; $display("FAIL wr_loads: got %b want 0101", {data_load, dirty_load}); end
        n_cmp++; if ({dirty_in, data_in_sel, hit_way} !== 3'b100) begin n_err++; $display("FAIL wr_ctl: got %b want 100", {dirty_in, data_in_sel, hit_way}); end
        n_cmp++; if ({tag_load, valid_load} !== 4'b0000) begin n_err++; $display("FAIL wr_tagvalid: got %b want 0000", {tag_load, valid_load}); end
        tick();
        mem_write = 1'b0;
        #1;
    endtask

    task automatic test_read_write_both();
        mem_address = 32'h0001_2340; mem_read = 1'b1; mem_write = 1'b1;
        #1;
        n_cmp++; if (mem_resp !== 1'b1) begin n_err++; $display("FAIL both_resp: got %b want 1", mem_resp); end
        n_cmp++; if ({data_load, dirty_load, dirty_in, hit_way} !== 6'b101011) begin n_err++; $display("FAIL both_write: got %b want 101011", {data_load, dirty_load, dirty_in, hit_way}); end
        tick();
        mem_read = 1'b0; mem_write = 1'b0;
        #1;
    endtask

    task automatic test_dirty_victim_miss();
        preload(1'b0, 3'd3, 24'h000001, 1'b1, 1'b0, 1'b1);
        preload(1'b1, 3'd3, 24'h0ABCDE, 1'b1, 1'b1, 1'b1);
        mem_address = 32'h0007_7760; mem_read = 1'b1;
        #1;
        n_cmp++; if ({mem_resp, pmem_read, pmem_write} !== 3'b000) begin n_err++; $display("FAIL dv_miss: got %b want 000", {mem_resp, pmem_read, pmem_write}); end
        tick();
        n_cmp++; if ({pmem_write, pmem_read} !== 2'b10) begin n_err++; $display("FAIL dv_wb_req: got %b want 10", {pmem_write, pmem_read}); end
        n_cmp++; if (pmem_address !== 32'h0ABC_DE60) begin n_err++; $display("FAIL dv_wb_addr: got %h want 0abcde60", pmem_address); end
        tick();
        n_cmp++; if ({pmem_write, pmem_address} !== {1'b1, 32'h0ABC_DE60}) begin n_err++; $display("FAIL dv_wb_hold: got %b/%h want 1/0abcde60", pmem_write, pmem_address); end
        pmem_resp = 1'b1;
        #1;
        n_cmp++; if ({dirty_load, dirty_in, tag_load, data_load} !== 7'b1000000) begin n_err++; $display("FAIL dv_wb_done: got %b want 1000000", {dirty_load, dirty_in, tag_load, data_load}); end
        tick();
        pmem_resp = 1'b0;
        #1;
        n_cmp++; if ({pmem_write, pmem_read} !== 2'b01) begin n_err++; $display("FAIL dv_alloc_req: got %b want 01", {pmem_write, pmem_read}); end
        n_cmp++; if (pmem_address !== 32'h0007_7760) begin n_err++; $display("FAIL dv_alloc_addr: got %h want 00077760", pmem_address); end
        n_cmp++; if (mem_resp !== 1'b0) begin n_err++; $display("FAIL dv_alloc_resp: got %b want 0", mem_resp); end
        pmem_resp = 1'b1;
        #1;
        n_cmp++; if ({tag_load, valid_load, data_load, dirty_load} !== 8'b10101010) begin n_err++; $display("FAIL dv_alloc_loads: got %b want 10101010", {tag_load, valid_load, data_load, dirty_load}); end
        tick();
        pmem_resp = 1'b0;
        #1;
        n_cmp++; if ({mem_resp, hit_way, lru_in} !== 3'b110) begin n_err++; $display("FAIL dv_hit: got %b want 110", {mem_resp, hit_way, lru_in}); end
        n_cmp++; if (dirty_out1 !== 1'b0) begin n_err++; $display("FAIL dv_clean: got %b want 0", dirty_out1); end
        tick();
        mem_read = 1'b0;
        #1;
    endtask

    task automatic test_async_reset_alloc();
        mem_address = 32'h0009_99A0; mem_read = 1'b1;
        tick();
        n_cmp++; if ({pmem_read, pmem_address} !== {1'b1, 32'h0009_99A0}) begin n_err++; $display("FAIL ar_alloc: got %b/%h want 1/000999a0", pmem_read, pmem_address); end
        pmem_resp = 1'b1;
        #1;
        n_cmp++; if ({tag_load, data_load} !== 4'b0101) begin n_err++; $display("FAIL ar_pre_loads: got %b want 0101", {tag_load, data_load}); end
        #2;
        rst = 1'b0;
        #1;
        n_cmp++; if ({pmem_read, pmem_write} !== 2'b00) begin n_err++; $display("FAIL ar_pmem_drop: got %b want 00", {pmem_read, pmem_write}); end
        n_cmp++; if ({tag_load, valid_load, data_load, dirty_load} !== 8'b0) begin n_err++; $display("FAIL ar_loads_drop: got %b want 00000000", {tag_load, valid_load, data_load, dirty_load}); end
        n_cmp++; if ({mem_resp, pmem_address} !== 33'b0) begin n_err++; $display("FAIL ar_outs_drop: got %b/%h want 0/00000000", mem_resp, pmem_address); end
        pmem_resp = 1'b0; mem_read = 1'b0;
        tick(); tick();
        rst = 1'b1;
        #1;
        n_cmp++; if ({mem_resp, pmem_read} !== 2'b00) begin n_err++; $display("FAIL ar_after: got %b want 00", {mem_resp, pmem_read}); end
        tick();
        n_cmp++; if ({mem_resp, pmem_read, pmem_write} !== 3'b000) begin n_err++; $display("FAIL ar_idle: got %b want 000", {mem_resp, pmem_read, pmem_write}); end
    endtask

    task automatic test_stray_and_drop();
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0;
        #1;
        n_cmp++; if ({pmem_read, pmem_write, tag_load} !== 4'b0000) begin n_err++; $display("FAIL stray_idle: got %b want 0000", {pmem_read, pmem_write, tag_load}); end
        // Set 5 is still empty: issue a miss, then withdraw it mid-refill.
        mem_address = 32'h0009_99A0; mem_read = 1'b1;
        tick();
        mem_read = 1'b0;
        #1;
        n_cmp++; if (pmem_read !== 1'b1) begin n_err++; $display("FAIL drop_alloc_held: got %b want 1", pmem_read); end
        pmem_resp = 1'b1;
        #1;
        n_cmp++; if ({tag_load, valid_load} !== 4'b0101) begin n_err++; $display("FAIL drop_completes: got %b want 0101", {tag_load, valid_load}); end
        tick();
        pmem_resp = 1'b0;
        #1;
        n_cmp++; if ({mem_resp, pmem_read} !== 2'b00) begin n_err++; $display("FAIL drop_idle: got %b want 00", {mem_resp, pmem_read}); end
        mem_read = 1'b1;
        #1;
        n_cmp++; if ({mem_resp, hit_way} !== 2'b10) begin n_err++; $display("FAIL drop_refilled_hit: got %b want 10", {mem_resp, hit_way}); end
        tick();
        mem_read = 1'b0;
        #1;
    endtask

    initial begin
        test_reset();
        test_cold_read_miss();
        test_read_hit_way1();
        test_write_hit();
        test_read_write_both();
        test_dirty_victim_miss();
        test_async_reset_alloc();
        test_stray_and_drop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_cache_control
`default_nettype wire
